// File: rtl/npc_pkg.sv
// Shared definitions for the fetch-stage next-PC predictor.
//   DEFAULT_RESET_PC : fetch address after reset
//   CTR_WEAK_TAKEN   : counter value given to a freshly allocated BTB entry
//   btb_entry_t      : one BTB entry as seen by the read port
//   ctr_next()       : 2-bit saturating counter step
package npc_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [1:0]  CTR_WEAK_TAKEN   = 2'b10;

  // Tag is carried zero-extended to 32 bits so the type is independent of
  // the BTB index width.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                          input logic       taken);
    logic [1:0] r;
    r = ctr;
    if (taken) begin
      if (ctr != 2'b11) r = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) r = ctr - 2'b01;
    end
    return r;
  endfunction

endpackage

// File: rtl/npc_predict_btb_store.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
//   i_clk, i_rst      : clock, async active-high reset (clears valid bits only)
//   i_rd_pc           : combinational lookup address
//   o_rd_hit          : valid entry with matching tag at i_rd_pc
//   o_rd_ctr          : counter of the indexed entry
//   o_rd_target       : target of the indexed entry
//   i_upd_valid       : train with a resolved control instruction this edge
//   i_upd_pc          : address of the resolved instruction
//   i_upd_target      : resolved target
//   i_upd_taken       : resolved direction
module btb_store
  import npc_pkg::*;
#(
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  CTR_INIT = CTR_WEAK_TAKEN
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_rd_pc,
  output logic        o_rd_hit,
  output logic [1:0]  o_rd_ctr,
  output logic [31:0] o_rd_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_taken
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [31:0]      r_target [DEPTH];
  logic [1:0]       r_ctr    [DEPTH];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  btb_entry_t       w_rd_entry;
  logic             w_unused;

  assign w_rd_idx  = i_rd_pc[IDX_W+1:2];
  assign w_rd_tag  = i_rd_pc[31:IDX_W+2];
  assign w_upd_idx = i_upd_pc[IDX_W+1:2];
  assign w_upd_tag = i_upd_pc[31:IDX_W+2];

  // Word-offset bits never take part in indexing or tagging.
  assign w_unused = ^{i_rd_pc[1:0], i_upd_pc[1:0]};

  always_comb begin
    w_rd_entry.valid  = r_valid[w_rd_idx];
    w_rd_entry.tag    = 32'(r_tag[w_rd_idx]);
    w_rd_entry.target = r_target[w_rd_idx];
    w_rd_entry.ctr    = r_ctr[w_rd_idx];
  end

  assign o_rd_hit    = w_rd_entry.valid && (w_rd_entry.tag == 32'(w_rd_tag));
  assign o_rd_ctr    = w_rd_entry.ctr;
  assign o_rd_target = w_rd_entry.target;

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Only the valid bits are reset; payload arrays need no reset because
  // they are never observed through an invalid entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_upd_valid && !w_upd_hit && i_upd_taken) begin
      r_valid[w_upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_upd_valid) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= ctr_next(r_ctr[w_upd_idx], i_upd_taken);
        if (i_upd_taken) r_target[w_upd_idx] <= i_upd_target;
      end else if (i_upd_taken) begin
        // Allocation overwrites whatever aliased entry held this index.
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= i_upd_target;
        r_ctr[w_upd_idx]    <= CTR_INIT;
      end
    end
  end

endmodule

// File: rtl/npc_predict.sv
// Fetch-stage next-PC generator with BTB prediction and MIPS delay slot.
//   clk, reset      : clock, async active-high reset
//   stall_F         : freeze PC and pending delay-slot state
//   redirect_valid  : decode redirect (wins over stall and pending)
//   redirect_pc     : redirect address
//   upd_valid       : BTB training strobe
//   upd_pc          : resolved instruction address
//   upd_target      : resolved target
//   upd_taken       : resolved direction
//   pc_F            : current fetch address
//   pred_taken_F    : instruction at pc_F predicted taken
//   pred_target_F   : predicted target (0 on a BTB miss)
module npc_predict
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  CTR_INIT = CTR_WEAK_TAKEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_F,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] pc_F,
  output logic        pred_taken_F,
  output logic [31:0] pred_target_F
);

  logic [31:0] r_pc;
  logic        r_pend;
  logic [31:0] r_pend_tgt;

  logic        w_hit;
  logic [1:0]  w_ctr;
  logic [31:0] w_target;
  logic        w_pred_taken;
  logic [31:0] w_pred_target;

  btb_store #(
    .IDX_W    (IDX_W),
    .CTR_INIT (CTR_INIT)
  ) u_btb (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_rd_pc      (r_pc),
    .o_rd_hit     (w_hit),
    .o_rd_ctr     (w_ctr),
    .o_rd_target  (w_target),
    .i_upd_valid  (upd_valid),
    .i_upd_pc     (upd_pc),
    .i_upd_target (upd_target),
    .i_upd_taken  (upd_taken)
  );

  // No new prediction while the delay slot is in fetch: the pending target
  // is already committed as the next address.
  assign w_pred_taken  = w_hit && w_ctr[1] && !r_pend;
  assign w_pred_target = w_hit ? w_target : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
    end else if (redirect_valid) begin
      r_pc   <= redirect_pc;
      r_pend <= 1'b0;
    end else if (stall_F) begin
      r_pc       <= r_pc;
      r_pend     <= r_pend;
      r_pend_tgt <= r_pend_tgt;
    end else if (r_pend) begin
      r_pc   <= r_pend_tgt;
      r_pend <= 1'b0;
    end else if (w_pred_taken) begin
      r_pc       <= r_pc + 32'd4;
      r_pend     <= 1'b1;
      r_pend_tgt <= w_pred_target;
    end else begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign pc_F          = r_pc;
  assign pred_taken_F  = w_pred_taken;
  assign pred_target_F = w_pred_target;

endmodule

// File: tb/tb_npc_predict.sv
module tb_npc_predict;

  localparam int IW = 4;
  localparam int N  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_F = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] pc_F;
  logic        pred_taken_F;
  logic [31:0] pred_target_F;

  npc_predict #(
    .RESET_PC (32'h0000_3000),
    .IDX_W    (IW),
    .CTR_INIT (2'b10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_F        (stall_F),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .pc_F           (pc_F),
    .pred_taken_F   (pred_taken_F),
    .pred_target_F  (pred_target_F)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the BTB remembers the full trained address per slot.
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ptgt;
  bit          m_valid [N];
  logic [31:0] m_key   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int ix(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    return m_valid[ix(a)] && ((m_key[ix(a)] >> (IW + 2)) == (a >> (IW + 2)));
  endfunction

  function automatic bit mpred();
    return mhit(m_pc) && (m_ctr[ix(m_pc)] >= 2) && !m_pend;
  endfunction

  function automatic logic [31:0] mtgt();
    return mhit(m_pc) ? m_tgt[ix(m_pc)] : 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc   = 32'h3000;
      m_pend = 0;
      m_ptgt = 32'h0;
      for (int i = 0; i < N; i++) m_valid[i] = 0;
    end else begin
      bit          p;
      logic [31:0] t;
      int          u;
      p = mpred();
      t = mtgt();
      if (redirect_valid) begin
        m_pc   = redirect_pc;
        m_pend = 0;
      end else if (stall_F) begin
        m_pc = m_pc;
      end else if (m_pend) begin
        m_pc   = m_ptgt;
        m_pend = 0;
      end else if (p) begin
        m_pc   = m_pc + 32'd4;
        m_pend = 1;
        m_ptgt = t;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      if (upd_valid) begin
        u = ix(upd_pc);
        if (mhit(upd_pc)) begin
          if (upd_taken) m_ctr[u] = (m_ctr[u] < 3) ? m_ctr[u] + 1 : 3;
          else           m_ctr[u] = (m_ctr[u] > 0) ? m_ctr[u] - 1 : 0;
          if (upd_taken) m_tgt[u] = upd_target;
        end else if (upd_taken) begin
          m_valid[u] = 1;
          m_key[u]   = upd_pc;
          m_tgt[u]   = upd_target;
          m_ctr[u]   = 2;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("pc_F", pc_F, m_pc);
    chk("pred_taken_F", 32'(pred_taken_F), 32'(mpred()));
    chk("pred_target_F", pred_target_F, mtgt());
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit exp_p [7];
    exp_p = '{1, 1, 1, 1, 1, 0, 0};

    // Reset state
    cyc(); cyc();
    chk("rst_pc", pc_F, 32'h3000);
    chk("rst_pred", 32'(pred_taken_F), 32'h0);
    chk("rst_tgt", pred_target_F, 32'h0);
    reset = 1'b0;
    cyc();

    // Train then predict
    upd_valid = 1; upd_pc = 32'h3008; upd_target = 32'h3040; upd_taken = 1;
    redirect_valid = 1; redirect_pc = 32'h3000;
    cyc();
    upd_valid = 0; redirect_valid = 0;
    chk("tp_pc0", pc_F, 32'h3000);
    cyc(); chk("tp_pc1", pc_F, 32'h3004);
    cyc(); chk("tp_pc2", pc_F, 32'h3008);
    chk("tp_pred", 32'(pred_taken_F), 32'h1);
    chk("tp_tgt", pred_target_F, 32'h3040);
    cyc(); chk("tp_slot", pc_F, 32'h300C);
    chk("tp_slot_pred", 32'(pred_taken_F), 32'h0);
    cyc(); chk("tp_target", pc_F, 32'h3040);

    // Stall during pending
    redirect_valid = 1; redirect_pc = 32'h3000;
    cyc(); redirect_valid = 0;
    cyc(); cyc(); cyc();
    chk("st_pc", pc_F, 32'h300C);
    stall_F = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("st_hold", pc_F, 32'h300C);
    end
    stall_F = 0;
    cyc(); chk("st_release", pc_F, 32'h3040);

    // Redirect beats stall and pending
    redirect_valid = 1; redirect_pc = 32'h3000;
    cyc(); redirect_valid = 0;
    cyc(); cyc(); cyc();
    stall_F = 1; redirect_valid = 1; redirect_pc = 32'h3100;
    cyc(); chk("rd_pc", pc_F, 32'h3100);
    stall_F = 0; redirect_valid = 0;
    cyc(); chk("rd_pend_cleared", pc_F, 32'h3104);

    // Reset mid-run with a pending delay slot at 0x3010
    upd_valid = 1; upd_pc = 32'h300C; upd_target = 32'h3080; upd_taken = 1;
    redirect_valid = 1; redirect_pc = 32'h300C;
    cyc(); upd_valid = 0; redirect_valid = 0;
    chk("mr_pred", 32'(pred_taken_F), 32'h1);
    cyc(); chk("mr_pc", pc_F, 32'h3010);
    #2 reset = 1'b1;
    #1;
    chk("mr_rst_pc", pc_F, 32'h3000);
    chk("mr_rst_pred", 32'(pred_taken_F), 32'h0);
    chk("mr_rst_tgt", pred_target_F, 32'h0);
    cyc(); reset = 1'b0;
    chk("mr_seq0", pc_F, 32'h3000);
    cyc(); chk("mr_seq1", pc_F, 32'h3004);
    cyc(); chk("mr_seq2", pc_F, 32'h3008);
    chk("mr_btb_cleared", 32'(pred_taken_F), 32'h0);

    // Alias eviction and same-cycle lookup/update
    stall_F = 1; redirect_valid = 1; redirect_pc = 32'h3048;
    upd_valid = 1; upd_pc = 32'h3008; upd_target = 32'h3040; upd_taken = 1;
    cyc(); redirect_valid = 0;
    chk("al_pc", pc_F, 32'h3048);
    chk("al_miss", 32'(pred_taken_F), 32'h0);
    upd_pc = 32'h3048; upd_target = 32'h3080;
    #1 chk("al_same_cycle", 32'(pred_taken_F), 32'h0);
    cyc(); upd_valid = 0;
    chk("al_new_pred", 32'(pred_taken_F), 32'h1);
    chk("al_new_tgt", pred_target_F, 32'h3080);
    redirect_valid = 1; redirect_pc = 32'h3008;
    cyc(); redirect_valid = 0;
    chk("al_evicted_pred", 32'(pred_taken_F), 32'h0);
    chk("al_evicted_tgt", pred_target_F, 32'h0);

    // Counter saturation at 0x3008 (held by stall)
    for (int i = 0; i < 7; i++) begin
      upd_valid = 1; upd_pc = 32'h3008; upd_target = 32'h3040;
      upd_taken = (i < 4);
      cyc();
      chk("sat_pred", 32'(pred_taken_F), 32'(exp_p[i]));
    end
    upd_valid = 0; upd_taken = 0; stall_F = 0;
    cyc();

    // Wrap and misaligned redirect
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    cyc(); redirect_valid = 0;
    chk("wrap_pc0", pc_F, 32'hFFFF_FFFC);
    cyc(); chk("wrap_pc1", pc_F, 32'h0);
    redirect_valid = 1; redirect_pc = 32'h3001;
    cyc(); redirect_valid = 0;
    cyc(); chk("misaligned", pc_F, 32'h3005);

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npc_predict.md
Name: npc_predict

Overview:
- Fetch-stage next-PC generator. Owns the PC register and a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Honours the MIPS branch delay slot. A branch fetched and predicted taken is followed by its delay slot (PC+4), and only then by the predicted target.
- Sits between the decode-stage target computation (branch/j/jr resolution) and instruction memory. Decode feeds back redirects and training updates.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- IDX_W, 4, BTB index width; the BTB holds 2**IDX_W entries.
- CTR_INIT, 2'b10, counter value written on a new allocation (weakly taken).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears the PC register, pending state and all BTB valid bits
- stall_F  in  1  hold fetch: PC and pending state are frozen
- redirect_valid  in  1  decode found a misprediction or unpredicted jump
- redirect_pc  in  32  correct next fetch address
- upd_valid  in  1  train BTB with a resolved control instruction
- upd_pc  in  32  address of the resolved branch or jump
- upd_target  in  32  resolved target (branch: pc+4+(imm<<2); j: {pc[31:28],imm28}; jr: register value)
- upd_taken  in  1  resolved direction
- pc_F  out  32  current fetch address (registered)
- pred_taken_F  out  1  BTB predicts that the instruction at pc_F is taken
- pred_target_F  out  32  predicted target for pc_F (valid only when pred_taken_F=1)

Behaviour:
- Reset (asynchronous) values:
  - pc_F=RESET_PC
  - pend=0, pend_tgt=0
  - all BTB valid bits=0
  - pred_taken_F=0, pred_target_F=0 (no hit is possible after reset).
- Lookup is combinational on pc_F:
  - idx=pc_F[IDX_W+1:2]; tag=pc_F[31:IDX_W+2].
  - hit = valid[idx] & (tag_mem[idx]==tag).
  - pred_taken_F = hit & ctr[idx][1] & ~pend.
  - pred_target_F = target from the BTB on a hit, else 0.
- Next-PC priority, evaluated each rising edge:
  1. redirect_valid: pc_F<=redirect_pc; pend<=0. Applies even when stall_F=1.
  2. stall_F: pc_F, pend and pend_tgt all hold.
  3. pend=1 (delay slot currently in fetch): pc_F<=pend_tgt; pend<=0.
  4. pred_taken_F=1: pc_F<=pc_F+4 (delay slot); pend<=1; pend_tgt<=pred_target_F.
  5. Otherwise: pc_F<=pc_F+4.
- Adder wraps modulo 2**32. No exception is raised. pc_F[1:0] is never checked; a misaligned redirect is passed through as-is.
- BTB training:
  - Writes are synchronous, on edges where upd_valid=1. Training is independent of stall_F and redirect_valid.
  - Hit on upd_pc:
    - Counter saturates: taken increments (max 2'b11); not-taken decrements (min 2'b00).
    - Target is rewritten only when upd_taken=1.
  - Miss with upd_taken=1: allocate the entry, overwriting any entry at that index: valid=1, tag, target, ctr=CTR_INIT.
  - Miss with upd_taken=0: no change.
- Same-cycle lookup and update of the same index: the lookup sees pre-update contents. The new contents are visible from the next cycle.
- Redirect while pend=1: the pending target is discarded. The decode redirect is authoritative.
- Latency:
  - Redirect takes effect in pc_F one cycle later.
  - A trained entry can first predict on the cycle after the update edge.

Decomposition:
- Shared package npc_pkg:
  - constants DEFAULT_RESET_PC and CTR_WEAK_TAKEN
  - a function for saturating 2-bit counter increment/decrement
  - typedef btb_entry_t {valid, tag, target, ctr}
- One sub-module, btb_store:
  - valid/tag/target/ctr arrays and the asynchronous reset of valid bits
  - combinational read port and synchronous update port with the counter logic
- The top level keeps only the PC register, the pend/pend_tgt registers and the priority mux.

Test Plan:
- Reset: assert reset mid-run at pc_F=0x3010 with pend=1 -> pc_F=0x3000 immediately, pend=0, pred_taken_F=0; after release, fetch sequence 0x3000, 0x3004, 0x3008.
- Train then predict: upd_valid with upd_pc=0x3008, upd_target=0x3040, taken=1, then redirect to 0x3000 -> fetch 0x3000, 0x3004, 0x3008 (pred_taken_F=1), 0x300C (delay slot), 0x3040.
- Counter saturation: four taken updates, then three not-taken updates on 0x3008 -> ctr goes 10, 11, 11, 11, 10, 01, 00; pred_taken_F=0 from the second not-taken onward.
- Stall during pending: pc_F=0x300C with pend=1, stall_F=1 for 3 cycles -> pc_F stays at 0x300C and pend holds; on release, the next pc_F is 0x3040.
- Redirect beats stall and pending: stall_F=1, pend=1, redirect_pc=0x3100 -> next pc_F=0x3100, pend=0.
- Alias eviction: IDX_W=4; train 0x3008 taken to 0x3040, then train 0x3048 (same index) taken to 0x3080 -> a lookup at 0x3008 misses; a lookup at 0x3048 predicts 0x3080. Same-cycle lookup/update of 0x3048 returns the old contents.
